demod_frame_ctrl: RTL and testbench
===================================

DEMOD_FRAME_CTRL -- requirements
Module: demod_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90: frame sync pattern, MSB received first.
REQ-002 SHALL have parameter SYNC_LEN, default 16: sync pattern length in bits (8..32).
REQ-003 SHALL have parameter FRAME_BYTES, default 32: payload bytes per frame (1..255).
REQ-004 SHALL have parameter MISS_MAX, default 3: consecutive sync misses that drop lock (1..7).
REQ-005 SHALL have port clk, input, 1: single system clock at the sample rate.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en_i, input, 1: enable; low forces hunt.
REQ-008 SHALL have port demo_ser_i, input, 1: serial demodulated bit from the I/Q combiner.
REQ-009 SHALL have port sync_flag_i, input, 1: one-cycle bit strobe; demo_ser_i is valid when this is high.
REQ-010 SHALL have port byte_o, output, 8: assembled payload byte, MSB first.
REQ-011 SHALL have port byte_valid_o, output, 1: one-cycle pulse; byte_o is valid.
REQ-012 SHALL have port frame_start_o, output, 1: high with byte_valid_o on payload byte 0.
REQ-013 SHALL have port frame_end_o, output, 1: high with byte_valid_o on payload byte FRAME_BYTES-1.
REQ-014 SHALL have port locked_o, output, 1: frame lock held.
REQ-015 SHALL have port sync_err_o, output, 1: one-cycle pulse on a sync mismatch while locked.

Function
REQ-016 On every sync_flag_i strobe, SHALL shift demo_ser_i into a SYNC_LEN-bit register, new bit at the LSB; no state changes without a strobe.
REQ-017 SHALL implement states HUNT, PAYLOAD and CHECK.
REQ-018 Sync comparison SHALL use the shifted value that includes the current strobe's bit; the result SHALL be registered on that strobe's clock edge.
REQ-019 In HUNT, an exact match SHALL give: PAYLOAD, locked_o=1, bit and byte counters=0, miss counter=0.
REQ-020 In PAYLOAD, each strobe SHALL shift a bit into the byte register; on the 8th bit, the byte SHALL be loaded into byte_o with byte_valid_o=1 on the next cycle (latency 1 clk from the strobe edge).
REQ-021 After byte FRAME_BYTES-1, SHALL go to CHECK with the bit counter=0.
REQ-022 In CHECK, SHALL count SYNC_LEN strobes and compare on the SYNC_LEN-th.
REQ-023 CHECK match SHALL give: miss counter=0, then PAYLOAD.
REQ-024 CHECK mismatch SHALL pulse sync_err_o and increment the miss counter.
REQ-025 If the miss counter after a CHECK mismatch equals MISS_MAX, SHALL go to HUNT with locked_o=0; otherwise SHALL go to PAYLOAD (flywheel).
REQ-026 en_i low SHALL take priority over all events: HUNT, counters cleared, locked_o=0, no output pulses; the sync shift register SHALL keep shifting.
REQ-027 byte_valid_o, frame_start_o, frame_end_o and sync_err_o SHALL be single-cycle pulses, low in all other cycles.
REQ-028 byte_o SHALL hold its last value between pulses.
REQ-029 When FRAME_BYTES=1, frame_start_o and frame_end_o SHALL both be high on the same byte.
REQ-030 The byte counter SHALL be 8 bits wide and SHALL never wrap past FRAME_BYTES-1.

Reset
REQ-031 While rst is high, SHALL force: state HUNT; all counters, shift registers and byte_o to 0; all outputs to 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial byte without emitting it.
REQ-033 After reset release, operation SHALL resume on the first sync_flag_i strobe.

Structure
REQ-034 Package demod_frame_pkg SHALL hold the state enum and the default SYNC_WORD, SYNC_LEN, FRAME_BYTES and MISS_MAX constants.
REQ-035 The sync shift register and comparator SHALL be one sub-module, sync_word_det, reused by both HUNT and CHECK.
REQ-036 All other logic SHALL be a single FSM with counters in demod_frame_ctrl.

Verification (FRAME_BYTES=4, strobe every 4 clks)
REQ-037 Bits 0xEB90 then 0x12,0x34,0x56,0x78 -> locked_o rises; bytes 12,34,56,78 emitted; frame_start_o on 0x12, frame_end_o on 0x78.
REQ-038 Random preamble 0xA5A5 containing no EB90 -> no byte_valid_o; locked_o=0.
REQ-039 Locked, next sync 0xEB91 -> sync_err_o one pulse; locked_o stays 1; the next 4 bytes are still emitted.
REQ-040 Three consecutive bad syncs with MISS_MAX=3 -> locked_o falls after the third; no bytes emitted afterwards until a new EB90 arrives.
REQ-041 rst pulse after 13 payload bits -> all outputs 0; no partial byte; relock on the next EB90.
REQ-042 en_i dropped mid-payload for 10 clks -> HUNT, locked_o=0; relock only on the following EB90.

Source files
------------

// File: rtl/demod_frame_pkg.sv
// Shared types and default parameters for the demodulator frame controller.
package demod_frame_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StPayload,
    StCheck
  } state_e;

  localparam logic [31:0] DefSyncWord   = 32'h0000_EB90;
  localparam int unsigned DefSyncLen    = 16;
  localparam int unsigned DefFrameBytes = 32;
  localparam int unsigned DefMissMax    = 3;

endpackage

// File: rtl/sync_word_det.sv
// Sync-word shift register and comparator, shared by frame hunt and per-frame sync checks.
module sync_word_det
  import demod_frame_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = DefSyncWord,
  parameter int unsigned SYNC_LEN  = DefSyncLen
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  input  logic bit_i,
  output logic match_o
);

  logic [SYNC_LEN-1:0] sr_q, sr_d;
  logic                unused_msb;

  assign sr_d       = {sr_q[SYNC_LEN-2:0], bit_i};
  assign unused_msb = sr_q[SYNC_LEN-1];

  // Compare the window that already contains this strobe's bit.
  assign match_o = strobe_i && (sr_d == SYNC_WORD[SYNC_LEN-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (strobe_i) begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/demod_frame_ctrl.sv
// Frame synchroniser: hunts for the sync word, deframes payload bytes and flywheels through
// a bounded number of missed sync words before dropping lock.
module demod_frame_ctrl
  import demod_frame_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD   = DefSyncWord,
  parameter int unsigned SYNC_LEN    = DefSyncLen,
  parameter int unsigned FRAME_BYTES = DefFrameBytes,
  parameter int unsigned MISS_MAX    = DefMissMax
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       demo_ser_i,
  input  logic       sync_flag_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       locked_o,
  output logic       sync_err_o
);

  localparam logic [7:0] LastByte    = 8'(FRAME_BYTES - 1);
  localparam logic [4:0] LastSyncBit = 5'(SYNC_LEN - 1);
  localparam logic [2:0] MissLimit   = 3'(MISS_MAX);

  state_e     state_q;
  logic [4:0] bit_cnt_q;
  logic [7:0] byte_cnt_q;
  logic [2:0] miss_cnt_q;
  logic [6:0] byte_sr_q;
  logic [7:0] byte_q;
  logic       byte_valid_q, frame_start_q, frame_end_q, locked_q, sync_err_q;

  logic       sync_match;
  logic [7:0] byte_nxt;
  logic [2:0] miss_inc;
  logic       last_byte;

  sync_word_det #(
    .SYNC_WORD(SYNC_WORD),
    .SYNC_LEN (SYNC_LEN)
  ) u_sync_word_det (
    .clk     (clk),
    .rst     (rst),
    .strobe_i(sync_flag_i),
    .bit_i   (demo_ser_i),
    .match_o (sync_match)
  );

  assign byte_nxt  = {byte_sr_q, demo_ser_i};
  assign miss_inc  = miss_cnt_q + 3'd1;
  assign last_byte = (byte_cnt_q == LastByte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StHunt;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      byte_sr_q     <= '0;
      byte_q        <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      sync_err_q    <= 1'b0;
      if (!en_i) begin
        state_q    <= StHunt;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        miss_cnt_q <= '0;
        byte_sr_q  <= '0;
        locked_q   <= 1'b0;
      end else if (sync_flag_i) begin
        case (state_q)
          StHunt: begin
            if (sync_match) begin
              state_q    <= StPayload;
              locked_q   <= 1'b1;
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
              miss_cnt_q <= '0;
              byte_sr_q  <= '0;
            end
          end
          StPayload: begin
            byte_sr_q <= byte_nxt[6:0];
            if (bit_cnt_q == 5'd7) begin
              byte_q        <= byte_nxt;
              byte_valid_q  <= 1'b1;
              frame_start_q <= (byte_cnt_q == 8'd0);
              frame_end_q   <= last_byte;
              bit_cnt_q     <= '0;
              if (last_byte) begin
                state_q    <= StCheck;
                byte_cnt_q <= '0;
              end else begin
                byte_cnt_q <= byte_cnt_q + 8'd1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
          StCheck: begin
            if (bit_cnt_q == LastSyncBit) begin
              bit_cnt_q <= '0;
              if (sync_match) begin
                miss_cnt_q <= '0;
                state_q    <= StPayload;
              end else begin
                sync_err_q <= 1'b1;
                if (miss_inc == MissLimit) begin
                  state_q    <= StHunt;
                  locked_q   <= 1'b0;
                  miss_cnt_q <= '0;
                end else begin
                  // Flywheel: trust frame timing and keep deframing.
                  miss_cnt_q <= miss_inc;
                  state_q    <= StPayload;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = byte_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign locked_o      = locked_q;
  assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_demod_frame_ctrl.sv
// Bench for demod_frame_ctrl: directed frame scenarios plus randomized bit streams, checked
// every cycle against a frame-position reference model.
module tb_demod_frame_ctrl;

  localparam int unsigned FB        = 4;
  localparam int unsigned SL        = 16;
  localparam int unsigned MM        = 3;
  localparam int unsigned FrameBits = 8 * FB + SL;
  localparam logic [15:0] Sync      = 16'hEB90;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic       demo_ser_i = 1'b0;
  logic       sync_flag_i = 1'b0;
  logic [7:0] byte_o;
  logic       byte_valid_o, frame_start_o, frame_end_o, locked_o, sync_err_o;

  always #5 clk = ~clk;

  demod_frame_ctrl #(
    .SYNC_WORD  (32'h0000_EB90),
    .SYNC_LEN   (SL),
    .FRAME_BYTES(FB),
    .MISS_MAX   (MM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .demo_ser_i   (demo_ser_i),
    .sync_flag_i  (sync_flag_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .frame_start_o(frame_start_o),
    .frame_end_o  (frame_end_o),
    .locked_o     (locked_o),
    .sync_err_o   (sync_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the current frame counted in received bits.
  logic        m_locked = 1'b0;
  int          m_pos = 0;
  int          m_miss = 0;
  logic [15:0] m_hist = '0;
  logic        e_valid = 1'b0, e_start = 1'b0, e_end = 1'b0, e_err = 1'b0;
  logic [7:0]  e_byte = '0;
  logic [7:0]  got_q[$];

  logic rst_cfg = 1'b1;
  logic en_cfg = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("locked", 32'(locked_o), 32'(m_locked));
    check_eq("byte_valid", 32'(byte_valid_o), 32'(e_valid));
    check_eq("frame_start", 32'(frame_start_o), 32'(e_start));
    check_eq("frame_end", 32'(frame_end_o), 32'(e_end));
    check_eq("sync_err", 32'(sync_err_o), 32'(e_err));
    check_eq("byte", 32'(byte_o), 32'(e_byte));
    if (byte_valid_o === 1'b1) got_q.push_back(byte_o);
  endtask

  task automatic model_step(input logic stb, input logic b);
    int p;
    e_valid = 1'b0;
    e_start = 1'b0;
    e_end   = 1'b0;
    e_err   = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_pos    = 0;
      m_miss   = 0;
      m_hist   = '0;
      e_byte   = '0;
    end else if (!en_i) begin
      m_locked = 1'b0;
      m_pos    = 0;
      m_miss   = 0;
      if (stb) m_hist = {m_hist[14:0], b};
    end else if (stb) begin
      m_hist = {m_hist[14:0], b};
      if (!m_locked) begin
        if (m_hist == Sync) begin
          m_locked = 1'b1;
          m_pos    = 0;
          m_miss   = 0;
        end
      end else begin
        p     = m_pos;
        m_pos = (m_pos + 1) % FrameBits;
        if (p < 8 * FB && p % 8 == 7) begin
          e_valid = 1'b1;
          e_byte  = m_hist[7:0];
          e_start = (p / 8 == 0);
          e_end   = (p / 8 == FB - 1);
        end
        if (p == FrameBits - 1) begin
          if (m_hist != Sync) begin
            e_err = 1'b1;
            m_miss++;
            if (m_miss == MM) begin
              m_locked = 1'b0;
              m_miss   = 0;
            end
          end else begin
            m_miss = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic stb, input logic b);
    @(negedge clk);
    check_outputs();
    rst         = rst_cfg;
    en_i        = en_cfg;
    sync_flag_i = stb;
    demo_ser_i  = b;
    model_step(stb, b);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, v[i]);
    end
  endtask

  task automatic flush();
    repeat (2) step(1'b0, 1'b0);
  endtask

  int n0;

  initial begin
    rst_cfg = 1'b1;
    en_cfg  = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    check_eq("reset_byte", 32'(byte_o), 32'h0);
    rst_cfg = 1'b0;
    en_cfg  = 1'b1;
    flush();

    // Preamble without a sync word.
    send_bits(32'hA5A5, 16);
    flush();
    check_eq("preamble_bytes", 32'(got_q.size()), 32'd0);

    // Lock and deframe a known frame.
    send_bits(32'(Sync), 16);
    send_bits(32'h1234_5678, 32);
    flush();
    check_eq("frame_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check_eq("frame_b0", 32'(got_q[0]), 32'h12);
      check_eq("frame_b1", 32'(got_q[1]), 32'h34);
      check_eq("frame_b2", 32'(got_q[2]), 32'h56);
      check_eq("frame_b3", 32'(got_q[3]), 32'h78);
    end

    // Single bad sync: flywheel keeps lock and still emits the next frame.
    send_bits(32'hEB91, 16);
    n0 = got_q.size();
    send_bits($urandom, 32);
    flush();
    check_eq("flywheel_lock", 32'(locked_o), 32'h1);
    check_eq("flywheel_bytes", 32'(got_q.size() - n0), 32'd4);

    // Good sync resets the miss count, then three consecutive misses drop lock.
    send_bits(32'(Sync), 16);
    send_bits($urandom, 32);
    for (int k = 0; k < 3; k++) begin
      send_bits(32'(Sync ^ (16'h1 << $urandom_range(0, 15))), 16);
      if (k < 2) send_bits($urandom, 32);
    end
    flush();
    check_eq("miss_unlock", 32'(locked_o), 32'h0);
    n0 = got_q.size();
    send_bits(32'h0, 32);
    flush();
    check_eq("unlocked_bytes", 32'(got_q.size() - n0), 32'd0);

    // Reset after 13 payload bits, then relock.
    send_bits(32'(Sync), 16);
    send_bits(32'h1ABC, 13);
    rst_cfg = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    flush();
    check_eq("mid_rst_byte", 32'(byte_o), 32'h0);
    rst_cfg = 1'b0;
    send_bits(32'(Sync), 16);
    n0 = got_q.size();
    send_bits(32'hCAFE_F00D, 32);
    flush();
    check_eq("relock_bytes", 32'(got_q.size() - n0), 32'd4);

    // Enable dropped mid-payload for 10 clocks.
    send_bits(32'(Sync), 16);
    send_bits(32'hABC, 12);
    en_cfg = 1'b0;
    for (int i = 0; i < 10; i++) step(i % 4 == 3, 1'($urandom));
    en_cfg = 1'b1;
    n0 = got_q.size();
    send_bits(32'h0, 32);
    flush();
    check_eq("en_drop_lock", 32'(locked_o), 32'h0);
    check_eq("en_drop_bytes", 32'(got_q.size() - n0), 32'd0);
    send_bits(32'(Sync), 16);
    send_bits($urandom, 32);

    // Randomized mix of syncs, corrupted syncs, payload and enable drops.
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1: send_bits(32'(Sync), 16);
        2: send_bits(32'(Sync ^ (16'h1 << $urandom_range(0, 15))), 16);
        3: begin
          en_cfg = 1'b0;
          for (int i = 0; i < int'($urandom_range(1, 12)); i++) step(1'($urandom), 1'($urandom));
          en_cfg = 1'b1;
        end
        default: send_bits($urandom, 8);
      endcase
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
